detecta_padrao_serial_param: RTL and testbench

Parametrised serial pattern detector. It shifts one bit per enabled cycle into a WIDTH-bit window and compares the window against a runtime-programmable pattern under a bit mask. It emits a registered one-cycle match pulse and keeps a saturating match counter. It supports overlapping and non-overlapping detection. It is the general-purpose successor of the fixed 4-bit serial detector and sits in the same serial-input datapaths, fed by shift/bit-stream sources.

---
 rtl/detecta_padrao_serial_param.sv | 94 +++++++++
 tb/tb_detecta_padrao_serial_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/detecta_padrao_serial_param.sv
// Serial pattern detector: WIDTH-bit shift window compared against a
// programmable pattern under a mask, with overlap control and saturating count.
module detecta_padrao_serial_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             overlap,
  input  logic             clear_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             full
);
  localparam int              FW       = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [WIDTH-1:0] sr_r;
  logic [FW-1:0]    fill_r;
  logic             match_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] window_s;
  logic [WIDTH-1:0] sr_next_s;
  logic [FW-1:0]    fill_inc_s;
  logic [FW-1:0]    fill_next_s;
  logic             hit_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Next-state: window shift, fill gating, hit decision and counter update.
  always_comb begin
    window_s    = (sr_r << 1'b1) | {{(WIDTH-1){1'b0}}, x};
    sr_next_s   = sr_r;
    fill_inc_s  = fill_r;
    fill_next_s = fill_r;
    hit_s       = 1'b0;
    cnt_next_s  = cnt_r;

    if (fill_r != FILL_MAX) begin
      fill_inc_s = fill_r + 1'b1;
    end else begin
      fill_inc_s = fill_r;
    end

    if (en) begin
      sr_next_s = window_s;
      hit_s     = (fill_inc_s == FILL_MAX) &&
                  (((window_s ^ pattern) & mask) == {WIDTH{1'b0}});
      // Non-overlap mode re-arms by demanding WIDTH fresh bits.
      if (hit_s && !overlap) begin
        fill_next_s = {FW{1'b0}};
      end else begin
        fill_next_s = fill_inc_s;
      end
    end else begin
      sr_next_s   = sr_r;
      fill_next_s = fill_r;
    end

    if (clear_cnt) begin
      cnt_next_s = hit_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + 1'b1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_r    <= {WIDTH{1'b0}};
      fill_r  <= {FW{1'b0}};
      match_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sr_r    <= sr_next_s;
      fill_r  <= fill_next_s;
      match_r <= hit_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign match       = match_r;
  assign match_count = cnt_r;
  assign full        = (fill_r == FILL_MAX);

endmodule

// File: tb/tb_detecta_padrao_serial_param.sv
// Scoreboard bench: stimulus pushes model expectations, monitor pops and compares.
module tb_detecta_padrao_serial_param;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset, en, x, overlap, clear_cnt;
  logic [W-1:0]  pattern, mask;
  logic          match;
  logic [CW-1:0] match_count;
  logic          full;

  detecta_padrao_serial_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .pattern(pattern), .mask(mask), .overlap(overlap), .clear_cnt(clear_cnt),
    .match(match), .match_count(match_count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          m;
    logic [CW-1:0] c;
    logic          f;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: received bit stream, bits since last arm, match tally.
  bit   stream[$];
  int   fresh = 0;
  int   mcnt  = 0;

  function automatic bit window_hits();
    for (int i = 0; i < W; i++) begin
      // i-th newest received bit lines up with window position i
      if (mask[i] && (stream[stream.size() - 1 - i] != pattern[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic e, input logic b, input logic clr);
    exp_t ex;
    bit   hit;
    reset = r; en = e; x = b; clear_cnt = clr;
    hit = 1'b0;
    if (!r) begin
      stream.delete();
      fresh = 0;
      mcnt  = 0;
    end else begin
      if (e) begin
        stream.push_back(b);
        if (stream.size() > 4 * W) void'(stream.pop_front());
        if (fresh < W) fresh++;
        hit = (fresh == W) && window_hits();
        if (hit && !overlap) fresh = 0;
      end
      if (clr) mcnt = hit ? 1 : 0;
      else if (hit && mcnt < (1 << CW) - 1) mcnt++;
    end
    ex.m = hit;
    ex.c = mcnt[CW-1:0];
    ex.f = (fresh == W);
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  task automatic send(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after the edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("match", {31'd0, match}, {31'd0, ex.m});
        check("match_count", {{(32-CW){1'b0}}, match_count}, {{(32-CW){1'b0}}, ex.c});
        check("full", {31'd0, full}, {31'd0, ex.f});
      end
    end
  end

  initial begin
    logic r, e, b, c;
    pattern = 4'b0000; mask = 4'b1111; overlap = 1'b1;
    reset = 1'b0; en = 1'b0; x = 1'b0; clear_cnt = 1'b0;
    do_reset(); do_reset();

    // basic detection
    pattern = 4'b0111; mask = 4'b1111; overlap = 1'b1;
    send(5, 32'b01111);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // overlap vs non-overlap on 1010 stream
    do_reset(); pattern = 4'b1010;
    send(8, 32'b10101010);
    do_reset(); overlap = 1'b0;
    send(8, 32'b10101010);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // startup gating on all-zero pattern, continuous and with idle gaps
    do_reset(); pattern = 4'b0000; overlap = 1'b1;
    send(5, 32'b00000);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // mask: two matching streams and one non-matching
    pattern = 4'b1001; mask = 4'b1001;
    do_reset(); send(4, 32'b1101);
    do_reset(); send(4, 32'b1011);
    do_reset(); send(4, 32'b0111);

    // counter saturation and clear
    do_reset(); mask = 4'b0000; overlap = 1'b1;
    send(7, 32'b1011001);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // reset on the completing edge
    do_reset(); pattern = 4'b0111; mask = 4'b1111;
    send(3, 32'b011);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send(3, 32'b111);
    send(4, 32'b0111);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) begin
        pattern = W'($urandom);
        mask    = W'($urandom);
        overlap = ($urandom_range(0, 1) == 1);
      end
      r = ($urandom_range(0, 99) >= 2);
      e = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 99) < 5);
      step(r, e, b, c);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
